// File: rtl/minirv_pkg.sv
// ============================================================================
// Module      : minirv_pkg
// Description : Shared types and default constants for the mini RISC-V core
//               data-memory path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package minirv_pkg;

    // Data-memory arbiter states: idle/arbitrate, CPU read return, external read return
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        EXT_RD = 2'd2
    } arb_state_t;

    // Default RAM word-address width
    localparam int DMEM_ADDR_W    = 14;

    // Default number of consecutive denied external cycles before a forced grant
    localparam int ARB_STARVE_MAX = 4;

endpackage : minirv_pkg

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port synchronous-read data RAM between the
//               CPU load/store path and an external requester. Stalls the CPU
//               for read latency and lost arbitration; a saturating starvation
//               counter guarantees the external requester eventually wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import minirv_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    // Counter is 4 bits wide: STARVE_MAX is limited to 1..15
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic [3:0]        starve_q, starve_d;

    logic              cpu_req_w;
    logic              force_ext_w;
    logic              cpu_win_w;

    logic [31:0]       cpu_rdata_w;
    logic              cpu_stall_w;
    logic              ext_gnt_w;
    logic              ext_rvalid_w;
    logic [31:0]       ext_rdata_w;
    logic              ram_we_w;
    logic [ADDR_W-1:0] ram_addr_w;
    logic [31:0]       ram_wdata_w;

    // Byte-offset and above-RAM address bits are deliberately ignored
    logic              unused_addr_bits_w;
    assign unused_addr_bits_w = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    assign cpu_req_w   = cpu_re | cpu_we;
    assign force_ext_w = ext_req & (starve_q == STARVE_LIMIT);
    assign cpu_win_w   = cpu_req_w & ~force_ext_w;

    // Arbitration, RAM port steering and next-state / counter computation
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        cpu_rdata_w  = 32'd0;
        cpu_stall_w  = 1'b0;
        ext_gnt_w    = 1'b0;
        ext_rvalid_w = 1'b0;
        ext_rdata_w  = 32'd0;
        ram_we_w     = 1'b0;
        ram_addr_w   = '0;
        ram_wdata_w  = 32'd0;
        case (state_q)
            IDLE: begin
                if (cpu_win_w) begin
                    ram_addr_w = cpu_addr[ADDR_W+1:2];
                    if (cpu_we) begin
                        // Store (also when cpu_re is high): completes this cycle
                        ram_we_w    = 1'b1;
                        ram_wdata_w = cpu_wdata;
                    end else begin
                        // Load: data returns next cycle, hold the CPU once
                        cpu_stall_w = 1'b1;
                        state_d     = CPU_RD;
                    end
                    if (ext_req && (starve_q < STARVE_LIMIT)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (ext_req) begin
                    ext_gnt_w   = 1'b1;
                    ram_we_w    = ext_we;
                    ram_addr_w  = ext_addr;
                    ram_wdata_w = ext_wdata;
                    cpu_stall_w = cpu_req_w;
                    starve_d    = 4'd0;
                    if (!ext_we) begin
                        state_d = EXT_RD;
                    end
                end
            end
            CPU_RD: begin
                cpu_rdata_w = ram_rdata;
                state_d     = IDLE;
            end
            EXT_RD: begin
                ext_rvalid_w = 1'b1;
                ext_rdata_w  = ram_rdata;
                cpu_stall_w  = cpu_req_w;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and starvation counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Outputs are forced to their idle values while reset is asserted, so a
    // reset mid-access takes effect on the ports immediately
    assign cpu_rdata  = rst_n ? cpu_rdata_w  : 32'd0;
    assign cpu_stall  = rst_n & cpu_stall_w;
    assign ext_gnt    = rst_n & ext_gnt_w;
    assign ext_rvalid = rst_n & ext_rvalid_w;
    assign ext_rdata  = rst_n ? ext_rdata_w  : 32'd0;
    assign ram_we     = rst_n & ram_we_w;
    assign ram_addr   = rst_n ? ram_addr_w   : '0;
    assign ram_wdata  = rst_n ? ram_wdata_w  : 32'd0;

endmodule : dmem_arbiter

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a
//               synchronous-read RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int ADDR_W = 14;

    logic              clk;
    logic              rst_n;
    logic              cpu_re;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [31:0]       ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [31:0]       ext_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    int nvec;
    int nerr;

    dmem_arbiter #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read single-port RAM model
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_re = 1'b1;  // request during reset must not leak to the ports
        #3;
        nvec++;
        if ({cpu_stall, ext_gnt, ext_rvalid, ram_we, ram_addr, ram_wdata, cpu_rdata, ext_rdata} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: stall=%0b gnt=%0b rvalid=%0b we=%0b addr=%0h wdata=%0h crd=%0h erd=%0h, expected all 0",
                     cpu_stall, ext_gnt, ext_rvalid, ram_we, ram_addr, ram_wdata, cpu_rdata, ext_rdata);
        end
        cpu_re = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        nvec++;
        if ({cpu_stall, ext_gnt, ram_we, ram_addr, ram_wdata} !== '0) begin
            nerr++;
            $display("FAIL idle_outputs: stall=%0b gnt=%0b we=%0b addr=%0h wdata=%0h, expected all 0",
                     cpu_stall, ext_gnt, ram_we, ram_addr, ram_wdata);
        end
    endtask

    task automatic test_cpu_store_load();
        cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1;
        nvec++;
        if ({ram_we, ram_addr, ram_wdata, cpu_stall} !== {1'b1, 14'd4, 32'hDEADBEEF, 1'b0}) begin
            nerr++;
            $display("FAIL cpu_store: we=%0b addr=%0h wdata=%0h stall=%0b, expected 1/4/deadbeef/0",
                     ram_we, ram_addr, ram_wdata, cpu_stall);
        end
        tick();
        cpu_we = 1'b0; cpu_re = 1'b1;
        #1;
        nvec++;
        if ({cpu_stall, ram_we, ram_addr} !== {1'b1, 1'b0, 14'd4}) begin
            nerr++;
            $display("FAIL cpu_load_issue: stall=%0b we=%0b addr=%0h, expected 1/0/4", cpu_stall, ram_we, ram_addr);
        end
        tick();
        nvec++;
        if ({cpu_stall, ram_we, cpu_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
            nerr++;
            $display("FAIL cpu_load_data: stall=%0b we=%0b rdata=%0h, expected 0/0/deadbeef", cpu_stall, ram_we, cpu_rdata);
        end
        cpu_re = 1'b0;
        tick();
    endtask

    task automatic test_ext_read();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 14'd4;
        #1;
        nvec++;
        if ({ext_gnt, ext_rvalid, cpu_stall, ram_we, ram_addr} !== {1'b1, 1'b0, 1'b0, 1'b0, 14'd4}) begin
            nerr++;
            $display("FAIL ext_read_gnt: gnt=%0b rvalid=%0b stall=%0b we=%0b addr=%0h, expected 1/0/0/0/4",
                     ext_gnt, ext_rvalid, cpu_stall, ram_we, ram_addr);
        end
        tick();
        ext_req = 1'b0;
        #1;
        nvec++;
        if ({ext_gnt, ext_rvalid, cpu_stall, ext_rdata} !== {1'b0, 1'b1, 1'b0, 32'hDEADBEEF}) begin
            nerr++;
            $display("FAIL ext_read_rvalid: gnt=%0b rvalid=%0b stall=%0b rdata=%0h, expected 0/1/0/deadbeef",
                     ext_gnt, ext_rvalid, cpu_stall, ext_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        // Two rounds: the second proves the counter was cleared by the first grant
        for (int r = 0; r < 2; r++) begin
            ext_req = 1'b1; ext_we = 1'b1; ext_addr = 14'd8; ext_wdata = 32'd5 + 32'(r);
            cpu_we = 1'b1; cpu_addr = 32'h40;
            for (int i = 0; i < 4; i++) begin
                cpu_wdata = 32'hA0 + 32'(r * 16) + 32'(i);
                #1;
                nvec++;
                if ({ext_gnt, cpu_stall, ram_we, ram_addr} !== {1'b0, 1'b0, 1'b1, 14'd16}) begin
                    nerr++;
                    $display("FAIL starve_cpu_wins r%0d c%0d: gnt=%0b stall=%0b we=%0b addr=%0h, expected 0/0/1/10",
                             r, i, ext_gnt, cpu_stall, ram_we, ram_addr);
                end
                tick();
            end
            #1;
            nvec++;
            if ({ext_gnt, cpu_stall, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 1'b1, 14'd8, 32'd5 + 32'(r)}) begin
                nerr++;
                $display("FAIL starve_forced_gnt r%0d: gnt=%0b stall=%0b we=%0b addr=%0h wdata=%0h, expected 1/1/1/8/%0h",
                         r, ext_gnt, cpu_stall, ram_we, ram_addr, ram_wdata, 5 + r);
            end
            tick();
        end
        ext_req = 1'b0; cpu_we = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        // Saturate the counter with CPU stores while an external read waits
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 14'd8;
        cpu_we = 1'b1; cpu_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            cpu_wdata = 32'hC0 + 32'(i);
            tick();
        end
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h40;
        #1;
        nvec++;
        if ({ext_gnt, cpu_stall, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b0, 14'd8}) begin
            nerr++;
            $display("FAIL contend_gnt: gnt=%0b stall=%0b we=%0b addr=%0h, expected 1/1/0/8", ext_gnt, cpu_stall, ram_we, ram_addr);
        end
        tick();
        ext_req = 1'b0;
        #1;
        nvec++;
        if ({ext_rvalid, ext_rdata, cpu_stall} !== {1'b1, 32'd6, 1'b1}) begin
            nerr++;
            $display("FAIL contend_rvalid: rvalid=%0b rdata=%0h stall=%0b, expected 1/6/1", ext_rvalid, ext_rdata, cpu_stall);
        end
        tick();
        nvec++;
        if ({cpu_stall, ext_gnt, ram_addr} !== {1'b1, 1'b0, 14'd16}) begin
            nerr++;
            $display("FAIL contend_cpu_issue: stall=%0b gnt=%0b addr=%0h, expected 1/0/10", cpu_stall, ext_gnt, ram_addr);
        end
        tick();
        nvec++;
        if ({cpu_stall, cpu_rdata} !== {1'b0, 32'hB3}) begin
            nerr++;
            $display("FAIL contend_cpu_data: stall=%0b rdata=%0h, expected 0/b3", cpu_stall, cpu_rdata);
        end
        cpu_re = 1'b0;
        tick();
    endtask

    task automatic test_both_re_we();
        cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h12345678;
        #1;
        nvec++;
        if ({ram_we, cpu_stall, ram_addr, ram_wdata} !== {1'b1, 1'b0, 14'd64, 32'h12345678}) begin
            nerr++;
            $display("FAIL re_we_store: we=%0b stall=%0b addr=%0h wdata=%0h, expected 1/0/40/12345678",
                     ram_we, cpu_stall, ram_addr, ram_wdata);
        end
        tick();
        // Still IDLE (no CPU_RD), so a following load must stall
        cpu_we = 1'b0;
        #1;
        nvec++;
        if (cpu_stall !== 1'b1) begin
            nerr++;
            $display("FAIL re_we_no_cpu_rd: stall=%0b, expected 1", cpu_stall);
        end
        tick();
        nvec++;
        if ({cpu_stall, cpu_rdata} !== {1'b0, 32'h12345678}) begin
            nerr++;
            $display("FAIL re_we_readback: stall=%0b rdata=%0h, expected 0/12345678", cpu_stall, cpu_rdata);
        end
        cpu_re = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 14'd4;
        #1;
        nvec++;
        if (ext_gnt !== 1'b1) begin
            nerr++;
            $display("FAIL rstmid_gnt: gnt=%0b, expected 1", ext_gnt);
        end
        tick();
        ext_req = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h10;
        #1;
        nvec++;
        if ({ext_rvalid, cpu_stall} !== 2'b11) begin
            nerr++;
            $display("FAIL rstmid_in_ext_rd: rvalid=%0b stall=%0b, expected 1/1", ext_rvalid, cpu_stall);
        end
        #1;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({cpu_stall, ext_gnt, ext_rvalid, ram_we, ram_addr, ram_wdata, cpu_rdata, ext_rdata} !== '0) begin
            nerr++;
            $display("FAIL rstmid_async: stall=%0b gnt=%0b rvalid=%0b we=%0b addr=%0h erd=%0h, expected all 0",
                     cpu_stall, ext_gnt, ext_rvalid, ram_we, ram_addr, ext_rdata);
        end
        cpu_re = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        nvec++;
        if ({ext_rvalid, cpu_stall, ram_we, ram_addr} !== '0) begin
            nerr++;
            $display("FAIL rstmid_release: rvalid=%0b stall=%0b we=%0b addr=%0h, expected all 0",
                     ext_rvalid, cpu_stall, ram_we, ram_addr);
        end
        tick();
        // Back in IDLE: a fresh load issues and stalls once
        cpu_re = 1'b1; cpu_addr = 32'h10;
        #1;
        nvec++;
        if ({cpu_stall, ext_rvalid} !== 2'b10) begin
            nerr++;
            $display("FAIL rstmid_idle_load: stall=%0b rvalid=%0b, expected 1/0", cpu_stall, ext_rvalid);
        end
        tick();
        nvec++;
        if ({cpu_stall, cpu_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            nerr++;
            $display("FAIL rstmid_load_data: stall=%0b rdata=%0h, expected 0/deadbeef", cpu_stall, cpu_rdata);
        end
        cpu_re = 1'b0;
        tick();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 32'd0;
        rst_n = 1'b1;
        cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = 32'd0;

        test_reset();
        test_cpu_store_load();
        test_ext_read();
        test_starvation();
        test_contention();
        test_both_re_we();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_dmem_arbiter

`default_nettype wire
